// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: synchronises and debounces the raw button,
// turns each debounced press into a held request acknowledged by the
// traffic-light controller, then holds off new requests for a lockout period
// counted in 1 s ticks. A press during lockout is remembered and raised as
// soon as the lockout ends.
module ped_request_ctrl #(
  parameter logic [19:0] DEB_CNT   = 20'd999999,
  parameter logic [7:0]  LOCKOUT_S = 8'd30,
  parameter logic        BTN_ACT   = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_p,
  input  logic btn_raw,
  input  logic tick_1s,
  input  logic req_ack,
  output logic ped_req,
  output logic btn_level,
  output logic lockout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  // Synchroniser flops hold the raw button level; normalised after stage 2.
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        btn_pressed_s;

  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic        btn_level_q, btn_level_d;
  logic        press_q, press_d;

  state_e      state_q, state_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        deferred_q, deferred_d;
  logic        ped_req_q, ped_req_d;
  logic        lockout_q, lockout_d;

  // Synchroniser and debounce next-state: a level change is accepted only
  // after the synchronised input has disagreed with btn_level for DEB_CNT+1
  // consecutive cycles; the counter clears as soon as they agree again.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    sync1_d       = btn_raw;
    sync2_d       = sync1_q;
    btn_pressed_s = (sync2_q == BTN_ACT);
    deb_cnt_d     = deb_cnt_q;
    btn_level_d   = btn_level_q;
    press_d       = 1'b0;

    if (btn_pressed_s == btn_level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_CNT) begin
      btn_level_d = ~btn_level_q;
      deb_cnt_d   = '0;
      // Only the rising edge of the debounced level is an event.
      press_d     = ~btn_level_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 20'd1;
    end
  end

  // Synchroniser and debounce registers.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    if (sys_rst_p) begin
      sync1_q     <= ~BTN_ACT;
      sync2_q     <= ~BTN_ACT;
      deb_cnt_q   <= '0;
      btn_level_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      btn_level_q <= btn_level_d;
      press_q     <= press_d;
    end
  end

  // Request FSM next-state: acknowledge beats a simultaneous press, a press
  // during lockout is deferred, and the tick that ends lockout re-raises a
  // deferred (or same-cycle) press.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    deferred_d = deferred_q;

    unique case (state_q)
      IDLE: begin
        if (press_q) state_d = PENDING;
      end

      PENDING: begin
        if (req_ack) begin
          if (LOCKOUT_S == 8'd0) begin
            state_d = press_q ? PENDING : IDLE;
          end else begin
            lock_cnt_d = LOCKOUT_S;
            deferred_d = press_q;
            state_d    = LOCKOUT;
          end
        end
      end

      LOCKOUT: begin
        if (press_q) deferred_d = 1'b1;
        if (tick_1s) begin
          if (lock_cnt_q <= 8'd1) begin
            state_d    = (deferred_q || press_q) ? PENDING : IDLE;
            deferred_d = 1'b0;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q - 8'd1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
        deferred_d = 1'b0;
      end
    endcase

    // Outputs are registered straight from the next state.
    ped_req_d = (state_d == PENDING);
    lockout_d = (state_d == LOCKOUT);
  end

  // Request FSM registers; reset discards any pending request or lockout.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      deferred_q <= 1'b0;
      ped_req_q  <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      deferred_q <= deferred_d;
      ped_req_q  <= ped_req_d;
      lockout_q  <= lockout_d;
    end
  end

  assign ped_req   = ped_req_q;
  assign btn_level = btn_level_q;
  assign lockout   = lockout_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Testbench for ped_request_ctrl (DEB_CNT=4, LOCKOUT_S=3, active-low button).
// A behavioural model built on a sample-history window and integer
// bookkeeping predicts every output each cycle; directed scenarios add
// fixed-latency spot checks, followed by a randomized run.
module tb_ped_request_ctrl;

  localparam int DEB = 4;
  localparam int LK  = 3;

  logic sys_clk   = 1'b0;
  logic sys_rst_p = 1'b1;
  logic btn_raw   = 1'b1;
  logic tick_1s   = 1'b0;
  logic req_ack   = 1'b0;
  logic ped_req;
  logic btn_level;
  logic lockout;

  int n_checks = 0;
  int n_pass   = 0;

  ped_request_ctrl #(
    .DEB_CNT  (20'd4),
    .LOCKOUT_S(8'd3),
    .BTN_ACT  (1'b0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_p(sys_rst_p),
    .btn_raw  (btn_raw),
    .tick_1s  (tick_1s),
    .req_ack  (req_ack),
    .ped_req  (ped_req),
    .btn_level(btn_level),
    .lockout  (lockout)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state.
  bit m_pend;       // request pending
  bit m_def;        // press remembered during lockout
  bit m_level;      // debounced level
  bit m_rose;       // debounced level rose at the previous edge
  int m_rem;        // seconds of lockout remaining
  bit s_hist[$];    // pressed samples of btn_raw, [0] = newest edge

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs applied to it.
  task automatic model_step();
    bit press;
    bit flip;
    if (sys_rst_p) begin
      m_pend  = 0;
      m_def   = 0;
      m_rem   = 0;
      m_level = 0;
      m_rose  = 0;
      s_hist  = {};
      repeat (DEB + 3) s_hist.push_back(1'b0);
      return;
    end

    press = m_rose;
    if (m_pend) begin
      if (req_ack) begin
        m_pend = 0;
        if (LK == 0) m_pend = press;
        else begin
          m_rem = LK;
          m_def = press;
        end
      end
    end else if (m_rem > 0) begin
      if (press) m_def = 1;
      if (tick_1s) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pend = m_def;
          m_def  = 0;
        end
      end
    end else if (press) begin
      m_pend = 1;
    end

    // The debouncer sees each sample two edges late; it flips when the last
    // DEB+1 values it has seen all disagree with the current level.
    s_hist.push_front(btn_raw == 1'b0);
    void'(s_hist.pop_back());
    flip = 1;
    for (int i = 2; i <= DEB + 2; i++)
      if (s_hist[i] == m_level) flip = 0;
    m_rose = flip && !m_level;
    if (flip) m_level = !m_level;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    check("ped_req", ped_req, m_pend);
    check("lockout", lockout, m_rem > 0);
    check("btn_level", btn_level, m_level);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic tick_pulse();
    tick_1s = 1'b1;
    cycle();
    tick_1s = 1'b0;
    run(2);
  endtask

  task automatic ack_pulse();
    req_ack = 1'b1;
    cycle();
    req_ack = 1'b0;
  endtask

  task automatic press_release();
    btn_raw = 1'b0;
    run(10);
    btn_raw = 1'b1;
    run(10);
  endtask

  initial begin
    int seg;

    // 1: reset with button released, then idle.
    sys_rst_p = 1'b1;
    btn_raw   = 1'b1;
    run(2);
    check("rst_ped_req", ped_req, 1'b0);
    check("rst_lockout", lockout, 1'b0);
    check("rst_level", btn_level, 1'b0);
    sys_rst_p = 1'b0;
    run(20);
    check("idle_ped_req", ped_req, 1'b0);

    // 2: a 3-cycle bounce is rejected.
    btn_raw = 1'b0;
    run(3);
    btn_raw = 1'b1;
    run(10);
    check("bounce_level", btn_level, 1'b0);
    check("bounce_ped_req", ped_req, 1'b0);

    // 3: held press; level at edge 7, request at edge 8, held until ack.
    btn_raw = 1'b0;
    run(6);
    check("press_level_e6", btn_level, 1'b0);
    run(1);
    check("press_level_e7", btn_level, 1'b1);
    check("press_req_e7", ped_req, 1'b0);
    run(1);
    check("press_req_e8", ped_req, 1'b1);
    run(5);
    btn_raw = 1'b1;
    run(12);
    check("req_held", ped_req, 1'b1);
    ack_pulse();
    check("ack_req_drop", ped_req, 1'b0);
    check("ack_lockout", lockout, 1'b1);

    // 4: three ticks without a press end lockout in IDLE.
    tick_pulse();
    tick_pulse();
    check("lock_after_2", lockout, 1'b1);
    tick_1s = 1'b1;
    cycle();
    tick_1s = 1'b0;
    check("lock_end", lockout, 1'b0);
    check("lock_end_req", ped_req, 1'b0);
    run(5);

    // 5: press during lockout is deferred and raised on the exiting tick.
    press_release();
    ack_pulse();
    press_release();
    check("defer_no_req", ped_req, 1'b0);
    tick_pulse();
    tick_pulse();
    tick_1s = 1'b1;
    cycle();
    tick_1s = 1'b0;
    check("defer_req", ped_req, 1'b1);
    check("defer_lock_off", lockout, 1'b0);

    // 6: reset discards a pending request and a running lockout.
    sys_rst_p = 1'b1;
    cycle();
    sys_rst_p = 1'b0;
    check("rst_drops_req", ped_req, 1'b0);
    run(3);
    press_release();
    ack_pulse();
    check("lock_before_rst", lockout, 1'b1);
    sys_rst_p = 1'b1;
    cycle();
    sys_rst_p = 1'b0;
    check("rst_drops_lock", lockout, 1'b0);
    run(3);

    // 6b: press and ack in the same cycle -> lockout with deferred request.
    press_release();
    btn_raw = 1'b0;
    run(7);
    req_ack = 1'b1;
    cycle();
    req_ack = 1'b0;
    btn_raw = 1'b1;
    check("both_lockout", lockout, 1'b1);
    check("both_req_drop", ped_req, 1'b0);
    run(10);
    tick_pulse();
    tick_pulse();
    tick_1s = 1'b1;
    cycle();
    tick_1s = 1'b0;
    check("both_deferred_req", ped_req, 1'b1);
    ack_pulse();

    // Randomized run against the model.
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        seg     = $urandom_range(1, 20);
      end
      seg--;
      tick_1s   = ($urandom_range(0, 15) == 0);
      req_ack   = ($urandom_range(0, 7) == 0);
      sys_rst_p = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
